// File: rtl/dd_debounce_if.sv
// Debouncer channel bundle: synchronised levels and enable in, debounced levels,
// edge pulses and busy out.
interface dd_debounce_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] data_sync_i;
  logic             en_i;
  logic [WIDTH-1:0] data_deb_o;
  logic [WIDTH-1:0] rise_p_o;
  logic [WIDTH-1:0] fall_p_o;
  logic             busy_o;

  modport master (
    output data_sync_i, en_i,
    input  data_deb_o, rise_p_o, fall_p_o, busy_o
  );

  modport slave (
    input  data_sync_i, en_i,
    output data_deb_o, rise_p_o, fall_p_o, busy_o
  );
endinterface

// File: rtl/dd_debounce.sv
// Per-bit debouncer with rise/fall pulses. Each channel accepts a new level only
// after STABLE_CYCLES consecutive differing samples.
module dd_debounce_lane #(
  parameter int   STABLE_CYCLES = 1000,
  parameter int   CNT_W         = 16,
  parameter logic RST_BIT       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync,
  output logic deb,
  output logic rise,
  output logic fall,
  output logic chk_nxt
);
  typedef enum logic {STABLE = 1'b0, CHECK = 1'b1} state_t;

  // Comparing against N-1 avoids the cnt+1 carry out of CNT_W bits.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             deb_nxt, rise_nxt, fall_nxt, acc;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    deb_nxt   = deb;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    acc       = 1'b0;
    if (!en) begin
      state_nxt = STABLE;
      cnt_nxt   = '0;
    end else if (sync != deb) begin
      if (state == STABLE && STABLE_CYCLES > 1) begin
        state_nxt = CHECK;
        cnt_nxt   = CNT_W'(1);
      end else if (state == STABLE || cnt == LAST) begin
        acc = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else begin
      // An equal sample while checking is a bounce: drop the count silently.
      state_nxt = STABLE;
      cnt_nxt   = '0;
    end
    if (acc) begin
      state_nxt = STABLE;
      cnt_nxt   = '0;
      deb_nxt   = sync;
      rise_nxt  = sync;
      fall_nxt  = ~sync;
    end
  end

  assign chk_nxt = (state_nxt == CHECK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE;
      cnt   <= '0;
      deb   <= RST_BIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      deb   <= deb_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end
endmodule

module dd_debounce #(
  parameter int               WIDTH         = 1,
  parameter int               STABLE_CYCLES = 1000,
  parameter int               CNT_W         = 16,
  parameter logic [WIDTH-1:0] RST_VAL       = '0
) (
  input logic          clk,
  input logic          rst_n,
  dd_debounce_if.slave bus
);
  logic [WIDTH-1:0] deb, rise, fall, chk_nxt;
  logic             busy;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    dd_debounce_lane #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W),
      .RST_BIT      (RST_VAL[g])
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (bus.en_i),
      .sync   (bus.data_sync_i[g]),
      .deb    (deb[g]),
      .rise   (rise[g]),
      .fall   (fall[g]),
      .chk_nxt(chk_nxt[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= 1'b0;
    else        busy <= |chk_nxt;
  end

  assign bus.data_deb_o = deb;
  assign bus.rise_p_o   = rise;
  assign bus.fall_p_o   = fall;
  assign bus.busy_o     = busy;
endmodule

// File: tb/tb_dd_debounce.sv
// Directed bench for dd_debounce: stimulus pushes per-edge expectations into a
// scoreboard queue; a monitor pops and compares on each falling edge.
module tb_dd_debounce;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dd_debounce_if #(.WIDTH(1)) ia ();
  dd_debounce_if #(.WIDTH(4)) ib ();
  dd_debounce_if #(.WIDTH(1)) ic ();
  dd_debounce_if #(.WIDTH(1)) id ();

  dd_debounce #(.WIDTH(1), .STABLE_CYCLES(4), .CNT_W(16), .RST_VAL(1'b0))
    u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  dd_debounce #(.WIDTH(4), .STABLE_CYCLES(8), .CNT_W(16), .RST_VAL(4'b0100))
    u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  dd_debounce #(.WIDTH(1), .STABLE_CYCLES(1), .CNT_W(16), .RST_VAL(1'b0))
    u_c (.clk(clk), .rst_n(rst_n), .bus(ic));
  dd_debounce #(.WIDTH(1), .STABLE_CYCLES(15), .CNT_W(4), .RST_VAL(1'b0))
    u_d (.clk(clk), .rst_n(rst_n), .bus(id));

  typedef struct {
    int         dut;
    logic [3:0] deb;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       busy;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [12:0] observe(input int dut);
    case (dut)
      0:       return {3'b0, ia.data_deb_o, 3'b0, ia.rise_p_o, 3'b0, ia.fall_p_o, ia.busy_o};
      1:       return {ib.data_deb_o, ib.rise_p_o, ib.fall_p_o, ib.busy_o};
      2:       return {3'b0, ic.data_deb_o, 3'b0, ic.rise_p_o, 3'b0, ic.fall_p_o, ic.busy_o};
      default: return {3'b0, id.data_deb_o, 3'b0, id.rise_p_o, 3'b0, id.fall_p_o, id.busy_o};
    endcase
  endfunction

  task automatic push(input int dut, input logic [3:0] deb, input logic [3:0] rise,
                      input logic [3:0] fall, input logic busy, input string nm);
    exp_t e;
    e.dut = dut; e.deb = deb; e.rise = rise; e.fall = fall; e.busy = busy; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic drive(input int dut, input logic [3:0] din, input logic en);
    case (dut)
      0:       begin ia.data_sync_i = din[0]; ia.en_i = en; end
      1:       begin ib.data_sync_i = din;    ib.en_i = en; end
      2:       begin ic.data_sync_i = din[0]; ic.en_i = en; end
      default: begin id.data_sync_i = din[0]; id.en_i = en; end
    endcase
  endtask

  // Called at a falling edge; expectation is for the state after the next rising edge.
  task automatic step(input int dut, input logic [3:0] din, input logic en,
                      input logic [3:0] deb, input logic [3:0] rise, input logic [3:0] fall,
                      input logic busy, input string nm);
    drive(dut, din, en);
    @(posedge clk);
    #1;
    push(dut, deb, rise, fall, busy, nm);
    @(negedge clk);
  endtask

  // Monitor
  initial begin
    exp_t        e;
    logic [12:0] act, want;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        e    = sbq.pop_front();
        act  = observe(e.dut);
        want = {e.deb, e.rise, e.fall, e.busy};
        checks++;
        if (act !== want) begin
          failures++;
          $display("FAIL %s dut%0d t=%0t: got deb=%b rise=%b fall=%b busy=%b, want deb=%b rise=%b fall=%b busy=%b",
                   e.nm, e.dut, $time, act[12:9], act[8:5], act[4:1], act[0],
                   want[12:9], want[8:5], want[4:1], want[0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [0:14] t2_din, t2_deb, t2_rise, t2_fall, t2_busy;
    logic [0:5]  t6_din, t6_rise, t6_fall;
    t2_din  = 15'b000001110011111;
    t2_deb  = 15'b111000000000011;
    t2_rise = 15'b000000000000010;
    t2_fall = 15'b000100000000000;
    t2_busy = 15'b111001110011100;
    t6_din  = 6'b100110;
    t6_rise = 6'b100100;
    t6_fall = 6'b010001;

    ia.data_sync_i = 1'b0;    ia.en_i = 1'b1;
    ib.data_sync_i = 4'b0100; ib.en_i = 1'b1;
    ic.data_sync_i = 1'b0;    ic.en_i = 1'b1;
    id.data_sync_i = 1'b0;    id.en_i = 1'b1;
    rst_n = 1'b0;
    #3;
    push(0, 4'b0000, 4'b0, 4'b0, 1'b0, "reset_a");
    push(1, 4'b0100, 4'b0, 4'b0, 1'b0, "reset_b");
    push(2, 4'b0000, 4'b0, 4'b0, 1'b0, "reset_c");
    push(3, 4'b0000, 4'b0, 4'b0, 1'b0, "reset_d");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean step, N=4: input high from edge 10, accept at edge 13
    for (int e = 0; e < 15; e++)
      step(0, 4'(e >= 10), 1'b1, 4'(e >= 13), 4'(e == 13), 4'b0,
           (e >= 10 && e <= 12), "t1_clean_step");

    // Fall back to 0, then a 3-cycle bounce, then a clean 4-cycle high
    for (int e = 0; e < 15; e++)
      step(0, 4'(t2_din[e]), 1'b1, 4'(t2_deb[e]), 4'(t2_rise[e]), 4'(t2_fall[e]),
           t2_busy[e], "t2_bounce");

    // Independent channels, N=8: bit0 rises at edge 5, bit2 falls at edge 7
    for (int e = 0; e < 16; e++)
      step(1, (e < 5) ? 4'b0100 : (e < 7) ? 4'b0101 : 4'b0001, 1'b1,
           (e < 12) ? 4'b0100 : (e < 14) ? 4'b0101 : 4'b0001,
           (e == 12) ? 4'b0001 : 4'b0000,
           (e == 14) ? 4'b0100 : 4'b0000,
           (e >= 5 && e <= 13), "t3_channels");

    // Enable freeze: bit1 rises, en low for edges 5..7, accept 8 edges after re-enable
    for (int e = 0; e < 17; e++)
      step(1, 4'b0011, !(e >= 5 && e <= 7),
           (e >= 15) ? 4'b0011 : 4'b0001,
           (e == 15) ? 4'b0010 : 4'b0000, 4'b0000,
           (e <= 4) || (e >= 8 && e <= 14), "t4_enable");

    // Reset mid-count: partial count on bit3 is discarded
    for (int e = 0; e < 6; e++)
      step(1, 4'b1011, 1'b1, 4'b0011, 4'b0, 4'b0, 1'b1, "t5_precount");
    #2;
    rst_n = 1'b0;
    #1;
    push(1, 4'b0100, 4'b0, 4'b0, 1'b0, "t5_async_reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 9; e++)
      step(1, 4'b1011, 1'b1,
           (e >= 7) ? 4'b1011 : 4'b0100,
           (e == 7) ? 4'b1011 : 4'b0000,
           (e == 7) ? 4'b0100 : 4'b0000,
           (e <= 6), "t5_post_reset");

    // N=1: every change mirrored after one edge with a pulse, never busy
    for (int e = 0; e < 6; e++)
      step(2, 4'(t6_din[e]), 1'b1, 4'(t6_din[e]), 4'(t6_rise[e]), 4'(t6_fall[e]),
           1'b0, "t6_n1");

    // CNT_W=4, N=15: drop on the 15th sample is rejected, then a full 15 accepts
    for (int e = 0; e < 14; e++)
      step(3, 4'b0001, 1'b1, 4'b0, 4'b0, 4'b0, 1'b1, "t6_limit_count");
    step(3, 4'b0000, 1'b1, 4'b0, 4'b0, 4'b0, 1'b0, "t6_limit_reject");
    for (int e = 0; e < 16; e++)
      step(3, 4'b0001, 1'b1, 4'(e >= 14), 4'(e == 14), 4'b0, (e <= 13), "t6_limit_accept");

    @(negedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dd_debounce.md
# dd_debounce

Per-bit debouncer and edge detector for slow external inputs such as push-buttons, DIP switches and card-detect lines. It sits directly downstream of the two-flop level synchroniser, `dd_sync`, and runs in the same destination clock domain. A channel's output changes only after its synchronised input has held a new value for `STABLE_CYCLES` consecutive clocks. On each accepted change the block issues a single-cycle rise or fall pulse to the consuming logic (register file, interrupt controller).

## Interface
Parameters:
- `WIDTH`, 1: number of independent channels.
- `STABLE_CYCLES`, 1000: consecutive differing samples required to accept a change. Legal range is 1 to 2^CNT_W − 1.
- `CNT_W`, 16: width of each channel's counter.
- `RST_VAL`, 0: reset value of `data_deb_o`, per bit. Match this to the synchroniser's reset value.

Ports:
- `clk`  in  1: destination clock. Single clock domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `data_sync_i`  in  WIDTH: already-synchronised input levels. The block adds no metastability protection.
- `en_i`  in  1: global enable. Low means freeze.
- `data_deb_o`  out  WIDTH: debounced levels, registered.
- `rise_p_o`  out  WIDTH: one-cycle pulse when a channel's debounced level goes 0→1.
- `fall_p_o`  out  WIDTH: one-cycle pulse when a channel's debounced level goes 1→0.
- `busy_o`  out  1: high while any channel is in CHECK, registered.

## Operation
- Each channel has its own two-state FSM (STABLE, CHECK) and a `CNT_W`-bit counter `cnt`. Channels are fully independent.
- A sample is "differing" when `data_sync_i[b]` ≠ `data_deb_o[b]`.
- STABLE:
  - Equal sample: no action.
  - Differing sample, `STABLE_CYCLES`==1: accept immediately.
  - Differing sample, `STABLE_CYCLES`>1: go to CHECK with `cnt`=1.
- CHECK:
  - Equal sample: the change is rejected as a bounce. Go to STABLE, `cnt`=0, no pulse.
  - Differing sample with `cnt`+1 == `STABLE_CYCLES`: accept. Go to STABLE, `cnt`=0.
  - Otherwise: `cnt`++.
- Accept, on the same edge:
  - `data_deb_o[b]` is set to the sample value.
  - `rise_p_o[b]` or `fall_p_o[b]` (matching the direction) goes high for exactly one cycle.
- `en_i`=0 (takes effect synchronously on every channel):
  - FSM forced to STABLE, `cnt`=0.
  - `data_deb_o` held.
  - Pulses forced to 0.
- `en_i` rising: counting restarts from zero. Any differing sample re-enters CHECK.
- `busy_o` is the registered OR of all channels' next-state == CHECK.
- The counter never wraps. The accept compare terminates it before `2^CNT_W − 1`.

## Timing
- Reset values, asserted asynchronously while `rst_n`=0:
  - `data_deb_o` = `RST_VAL`.
  - `rise_p_o` = `fall_p_o` = 0.
  - `busy_o` = 0.
  - All FSMs in STABLE, all `cnt` = 0.
- Reset deassertion mid-count: any partial count is discarded. No pulse is generated for any difference between `RST_VAL` and the input until `STABLE_CYCLES` differing samples have been taken after reset.
- Latency: if the first differing sample is taken at edge k and samples k..k+N−1 all differ (N = `STABLE_CYCLES`), then the accept happens at edge k+N−1:
  - `data_deb_o` changes after edge k+N−1.
  - The pulse is high during cycle k+N−1 → k+N only.
- Pulses never overlap on one bit. The minimum spacing between two accepts on the same bit is N cycles.
- `busy_o` follows CHECK entry and exit with one registered cycle of delay relative to the FSM's next-state.

## Test plan
1. **Clean step.** N=4, WIDTH=1. Input 0→1 at edge 10 and held. Required: `data_deb_o`=1 after edge 13; `rise_p_o` high for exactly one cycle after edge 13; `busy_o` high for cycles 11–13.
2. **Bounce rejection.** N=4. Input high for 3 cycles, then low. Required: `data_deb_o` stays 0, no pulse, `busy_o` returns to 0. Follow with a clean high held 4 cycles: one rise pulse.
3. **Independent channels.** WIDTH=4, N=8. Bit 0 rises at edge 5, bit 2 falls (from RST_VAL=4'b0100) at edge 7. Required: rise on bit 0 after edge 12 and fall on bit 2 after edge 14; other bits show no activity.
4. **Enable freeze.** N=8. Input rises, then `en_i` drops after 5 cycles and is raised 3 cycles later. Required: no pulse during the gap; accept 8 cycles after re-enable.
5. **Reset mid-count.** N=8. Input rises, then `rst_n` is pulsed low after 6 cycles. Required: outputs go to reset values immediately; the count restarts, and the accept occurs 8 cycles after the first post-reset edge.
6. **N=1 and counter limit.** With N=1, each input toggle is mirrored with one cycle of latency and pulses every change. With CNT_W=4, N=15: accept after exactly 15 cycles, with no wrap.
